// File: rtl/aes_key_sched_iter_if.sv
// Round-key port bundle for aes_key_sched_iter.
// master: the side that requests expansion and consumes round keys.
// slave:  the key-schedule engine.
interface aes_key_sched_iter_if;
  logic         start;
  logic         start_ready;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;
  logic         err;
  logic [3:0]   rd_round;
  logic [127:0] rd_data;

  modport master (
    output start, key_size, key_in, abort, rk_ready, rd_round,
    input  start_ready, rk_valid, rk_round, rk_data, done, err, rd_data
  );

  modport slave (
    input  start, key_size, key_in, abort, rk_ready, rd_round,
    output start_ready, rk_valid, rk_round, rk_data, done, err, rd_data
  );
endinterface

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle, round keys
// streamed over a valid/ready port with a single holding register.
// Optional macro AES_KSCHED_STORE_EN adds a 15-entry round-key store with a
// combinational random-access read port.
module aes_key_sched_iter #(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter bit          STALL_ON_OUT = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  aes_key_sched_iter_if.slave bus
);

  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTab[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDrain} state_e;

  state_e       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   kpos_q, kpos_d;  // i mod Nk
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  win_q [8];       // win_q[0] = w[i-1], win_q[Nk-1] = w[i-Nk]
  logic [31:0]  win_d [8];
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic         err_q, err_d;
  logic         done, load_out, stall, size_legal;
  logic [3:0]   nk, nr, nk_in;
  logic [2:0]   nk_m1;
  logic [5:0]   last_word, total_words;
  logic [31:0]  key_word [8];
  logic [31:0]  prev, back, sub_src, sub, w_new;
  logic [7:0]   rcon_next;

  // Decode the active mode and the mode being requested at start.
  always_comb begin
    nk = 4'd4;
    nr = 4'd10;
    case (mode_q)
      2'b01:   begin nk = 4'd6; nr = 4'd12; end
      2'b10:   begin nk = 4'd8; nr = 4'd14; end
      default: ;
    endcase
    nk_in      = 4'd4;
    size_legal = 1'b0;
    case (bus.key_size)
      2'b00:   size_legal = (MAX_KEY_BITS >= 128);
      2'b01:   begin nk_in = 4'd6; size_legal = (MAX_KEY_BITS >= 192); end
      2'b10:   begin nk_in = 4'd8; size_legal = (MAX_KEY_BITS >= 256); end
      default: ;
    endcase
    for (int k = 0; k < 8; k++) key_word[k] = bus.key_in[255 - 32*k -: 32];
  end

  assign nk_m1       = 3'(nk - 4'd1);
  assign last_word   = {nr, 2'b11};
  assign total_words = {nr, 2'b00} + 6'd4;

  // One shared SubWord: RotWord is applied first only on the rcon step.
  assign prev      = win_q[0];
  assign back      = win_q[nk_m1];
  assign sub_src   = (kpos_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub       = {sbox(sub_src[31:24]), sbox(sub_src[23:16]),
                      sbox(sub_src[15:8]), sbox(sub_src[7:0])};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next expanded word; the key is preloaded so that w[i-Nk] is key word i for i < Nk.
  always_comb begin
    if (i_q < {2'b00, nk}) begin
      w_new = back;
    end else if (kpos_q == 3'd0) begin
      w_new = back ^ sub ^ {rcon_q, 24'h0};
    end else if (nk == 4'd8 && kpos_q == 3'd4) begin
      w_new = back ^ sub;
    end else begin
      w_new = back ^ prev;
    end
  end

  assign stall = STALL_ON_OUT && (i_q[1:0] == 2'b11) && rk_valid_q && !bus.rk_ready;

  // FSM next state, expansion datapath and output-register control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    i_d        = i_q;
    kpos_d     = kpos_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    rk_valid_d = rk_valid_q;
    rk_round_d = rk_round_q;
    rk_data_d  = rk_data_q;
    err_d      = 1'b0;
    done       = 1'b0;
    load_out   = 1'b0;
    if (rk_valid_q && bus.rk_ready) rk_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (size_legal) begin
            state_d = StExpand;
            mode_d  = bus.key_size;
            i_d     = 6'd0;
            kpos_d  = 3'd0;
            rcon_d  = 8'h01;
            for (int j = 0; j < 8; j++) begin
              if (j < int'(nk_in)) win_d[j] = key_word[3'(int'(nk_in) - 1 - j)];
              else                 win_d[j] = 32'h0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StExpand: begin
        if (!stall) begin
          win_d[0] = w_new;
          for (int j = 1; j < 8; j++) win_d[j] = win_q[j-1];
          i_d    = (i_q == 6'd59) ? i_q : i_q + 6'd1;
          kpos_d = (kpos_q == nk_m1) ? 3'd0 : kpos_q + 3'd1;
          // Skip the advance after the last rcon use so rcon stops at its final value.
          if (kpos_q == 3'd0 && i_q >= {2'b00, nk} && i_q < total_words - {2'b00, nk}) begin
            rcon_d = rcon_next;
          end
          if (i_q[1:0] == 2'b11) begin
            load_out   = 1'b1;
            rk_valid_d = 1'b1;
            rk_round_d = i_q[5:2];
            rk_data_d  = {win_q[2], win_q[1], win_q[0], w_new};
          end
          if (i_q == last_word) state_d = StDrain;
        end
      end
      StDrain: begin
        if (rk_valid_q && bus.rk_ready && rk_round_q == nr) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.abort) begin
      state_d    = StIdle;
      rk_valid_d = 1'b0;
      rcon_d     = 8'h01;
      err_d      = 1'b0;
      done       = 1'b0;
      load_out   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= 2'b00;
      i_q        <= 6'd0;
      kpos_q     <= 3'd0;
      rcon_q     <= 8'h01;
      for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
      rk_data_q  <= 128'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      kpos_q     <= kpos_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      rk_valid_q <= rk_valid_d;
      rk_round_q <= rk_round_d;
      rk_data_q  <= rk_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.start_ready = (state_q == StIdle);
  assign bus.rk_valid    = rk_valid_q;
  assign bus.rk_round    = rk_round_q;
  assign bus.rk_data     = rk_data_q;
  assign bus.done        = done;
  assign bus.err         = err_q;

`ifdef AES_KSCHED_STORE_EN
  logic [127:0] store_q [15];

  // Capture every emitted round key at its round index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 15; k++) store_q[k] <= 128'h0;
    end else if (load_out) begin
      for (int k = 0; k < 15; k++) begin
        if (rk_round_d == 4'(k)) store_q[k] <= rk_data_d;
      end
    end
  end

  // Random-access read; index 15 has no entry and reads zero.
  always_comb begin
    bus.rd_data = 128'h0;
    for (int k = 0; k < 15; k++) begin
      if (bus.rd_round == 4'(k)) bus.rd_data = store_q[k];
    end
  end
`else
  logic unused_rd_round;
  logic unused_load_out;
  assign unused_rd_round = ^bus.rd_round;
  assign unused_load_out = load_out;
  assign bus.rd_data     = 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Directed bench for aes_key_sched_iter using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_iter;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk;
  logic reset;
  aes_key_sched_iter_if bus ();

  aes_key_sched_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [127:0] got_keys [15];
  int got_cnt, done_cyc, first_valid, order_bad, stable_bad, done_seen;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one expansion and collects round keys until done or a cycle budget runs out.
  // Cycle c is the cycle following the c-th rising edge after the start-accept edge.
  task automatic run_keys(input string tag, input logic [1:0] ks, input logic [255:0] key,
                          input int pct);
    logic         stalled;
    logic [127:0] held_d;
    logic [3:0]   held_r;
    got_cnt = 0; done_cyc = -1; first_valid = -1; order_bad = 0; stable_bad = 0;
    stalled = 1'b0; held_d = '0; held_r = '0;
    for (int k = 0; k < 15; k++) got_keys[k] = '0;
    @(posedge clk); #1;
    chk({tag, "_start_ready"}, 128'(bus.start_ready), 128'(1));
    bus.start = 1'b1; bus.key_size = ks; bus.key_in = key;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      bus.rk_ready = ($urandom_range(99, 0) < 32'(pct));
      #1;
      if (bus.rk_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (stalled && (bus.rk_data !== held_d || bus.rk_round !== held_r)) stable_bad++;
        if (bus.rk_ready) begin
          if (got_cnt < 15) got_keys[got_cnt] = bus.rk_data;
          if (bus.rk_round !== 4'(got_cnt)) order_bad++;
          got_cnt++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; held_d = bus.rk_data; held_r = bus.rk_round;
        end
      end else if (stalled) begin
        stable_bad++;
        stalled = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    bus.rk_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.key_size = 2'b00; bus.key_in = '0; bus.abort = 1'b0;
    bus.rk_ready = 1'b1; bus.rd_round = 4'd0;
    #2;
    chk("rst_start_ready", 128'(bus.start_ready), 128'(1));
    chk("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_err", 128'(bus.err), 128'(0));
    chk("rst_rk_round", 128'(bus.rk_round), 128'(0));
    chk("rst_rk_data", bus.rk_data, 128'h0);
    chk("rst_rd_data", bus.rd_data, 128'h0);
    @(posedge clk); #1 reset = 1'b0;

    // AES-128, consumer always ready
    run_keys("k128", 2'b00, {K128, 128'h0}, 100);
    chk("k128_first_valid", 128'(first_valid), 128'(4));
    chk("k128_count", 128'(got_cnt), 128'(11));
    chk("k128_done_cycle", 128'(done_cyc), 128'(44));
    chk("k128_order", 128'(order_bad), 128'(0));
    chk("k128_round0", got_keys[0], R128[0]);
    chk("k128_round1", got_keys[1], R128[1]);
    chk("k128_round10", got_keys[10], R128[10]);
    bus.rd_round = 4'd10; #1;
`ifdef AES_KSCHED_STORE_EN
    chk("store_rd10", bus.rd_data, R128[10]);
`else
    chk("store_rd10", bus.rd_data, 128'h0);
`endif
    bus.rd_round = 4'd15; #1;
    chk("store_rd15", bus.rd_data, 128'h0);

    // AES-192, started back-to-back
    run_keys("k192", 2'b01, {K192, 64'h0}, 100);
    chk("k192_count", 128'(got_cnt), 128'(13));
    chk("k192_done_cycle", 128'(done_cyc), 128'(52));
    chk("k192_round0", got_keys[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("k192_round1", got_keys[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("k192_round12", got_keys[12], 128'he98ba06f448c773c8ecc720401002202);

    // AES-256
    run_keys("k256", 2'b10, K256, 100);
    chk("k256_count", 128'(got_cnt), 128'(15));
    chk("k256_done_cycle", 128'(done_cyc), 128'(60));
    chk("k256_round1", got_keys[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("k256_round2", got_keys[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("k256_round14", got_keys[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // AES-128 with the consumer ready 30% of the time
    run_keys("bp", 2'b00, {K128, 128'h0}, 30);
    chk("bp_count", 128'(got_cnt), 128'(11));
    chk("bp_order", 128'(order_bad), 128'(0));
    chk("bp_stable", 128'(stable_bad), 128'(0));
    chk("bp_done_seen", 128'(done_cyc > 0), 128'(1));
    for (int r = 0; r < 11; r++) chk($sformatf("bp_round%0d", r), got_keys[r], R128[r]);

    // Illegal key size
    @(posedge clk); #1 bus.start = 1'b1; bus.key_size = 2'b11;
    @(posedge clk); #1 bus.start = 1'b0; #1;
    chk("ill_err_pulse", 128'(bus.err), 128'(1));
    chk("ill_start_ready", 128'(bus.start_ready), 128'(1));
    chk("ill_rk_valid", 128'(bus.rk_valid), 128'(0));
    @(posedge clk); #2;
    chk("ill_err_cleared", 128'(bus.err), 128'(0));

    // abort and start together in IDLE: abort wins
    @(posedge clk); #1 bus.start = 1'b1; bus.key_size = 2'b00; bus.abort = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0; #1;
    chk("abst_start_ready", 128'(bus.start_ready), 128'(1));
    repeat (5) @(posedge clk);
    #2;
    chk("abst_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("abst_err", 128'(bus.err), 128'(0));

    // abort at cycle 20 of a 256-bit run, then a 128-bit run
    @(posedge clk); #1 bus.start = 1'b1; bus.key_size = 2'b10; bus.key_in = K256;
    @(posedge clk); #1 bus.start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #2;
      if (bus.done === 1'b1) done_seen++;
    end
    chk("abort_busy", 128'(bus.start_ready), 128'(0));
    bus.abort = 1'b1; #1;
    if (bus.done === 1'b1) done_seen++;
    @(posedge clk); #1 bus.abort = 1'b0; #1;
    if (bus.done === 1'b1) done_seen++;
    chk("abort_start_ready", 128'(bus.start_ready), 128'(1));
    chk("abort_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("abort_no_done", 128'(done_seen), 128'(0));
    run_keys("post_abort", 2'b00, {K128, 128'h0}, 100);
    chk("post_abort_done_cycle", 128'(done_cyc), 128'(44));
    chk("post_abort_round1", got_keys[1], R128[1]);
    chk("post_abort_round10", got_keys[10], R128[10]);

    // asynchronous reset in the middle of a 192-bit run
    @(posedge clk); #1 bus.start = 1'b1; bus.key_size = 2'b01; bus.key_in = {K192, 64'h0};
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("pre_reset_valid", 128'(bus.rk_valid), 128'(1));
    reset = 1'b1; #1;
    chk("mid_rst_start_ready", 128'(bus.start_ready), 128'(1));
    chk("mid_rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("mid_rst_rk_round", 128'(bus.rk_round), 128'(0));
    chk("mid_rst_rk_data", bus.rk_data, 128'h0);
    chk("mid_rst_done", 128'(bus.done), 128'(0));
    @(posedge clk); #1 reset = 1'b0;
    run_keys("post_rst", 2'b01, {K192, 64'h0}, 100);
    chk("post_rst_count", 128'(got_cnt), 128'(13));
    chk("post_rst_done_cycle", 128'(done_cyc), 128'(52));
    chk("post_rst_round12", got_keys[12], 128'he98ba06f448c773c8ecc720401002202);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
